tf_conflict_monitor: RTL and testbench

Passive safety monitor for the T-intersection traffic light controller: samples the four 3-bit lamp outputs (M1, MT, M2, S) every clock and checks encoding legality, green/yellow conflicts between approaches, per-lamp sequencing, minimum yellow time and a stuck-pattern watchdog. It sits beside the light controller on the same clock. It latches the first fault seen as a sticky report, and `fault` serves as the board's force-all-red request.

---
 rtl/tf_pkg.sv | 44 ++++
 rtl/tf_lamp_checker.sv | 61 ++++++
 rtl/tf_conflict_monitor.sv | 128 ++++++++++++
 tb/tb_tf_conflict_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
// Shared lamp encodings, fault codes and lamp indices for the traffic-light
// conflict monitor.
package tf_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_ENC       = 3'd1,
    FC_CONFLICT  = 3'd2,
    FC_TRANS     = 3'd3,
    FC_SHORT_YEL = 3'd4,
    FC_STUCK     = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    L_M1 = 2'd0,
    L_MT = 2'd1,
    L_M2 = 2'd2,
    L_S  = 2'd3
  } lamp_idx_e;

  function automatic logic lamp_legal(input logic [2:0] v);
    return (v == LAMP_RED) || (v == LAMP_YEL) || (v == LAMP_GRN);
  endfunction

  // Lowest set lamp index; callers only use it when v is non-zero.
  function automatic lamp_idx_e first_lamp(input logic [3:0] v);
    lamp_idx_e idx;
    logic      found;
    idx   = L_M1;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        idx   = lamp_idx_e'(i[1:0]);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tf_lamp_checker.sv
// Per-lamp checker: previous-sample register, dwell counter, encoding,
// transition and short-yellow checks.
module tf_lamp_checker
  import tf_pkg::*;
#(
  parameter int unsigned CW      = 27,
  parameter int unsigned YEL_MIN = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] led,
  output logic       enc_err,
  output logic       trans_err,
  output logic       short_yel,
  output logic       active
);

  localparam logic [CW-1:0] YEL_MIN_C = CW'(YEL_MIN);

  logic [2:0]    prev;
  logic          prev_valid;
  logic [CW-1:0] dwell;
  logic          changed;
  logic          cur_ok;
  logic          prev_ok;

  assign changed = (led != prev);
  assign cur_ok  = lamp_legal(led);
  assign prev_ok = lamp_legal(prev);
  assign active  = (led == LAMP_GRN) || (led == LAMP_YEL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      dwell      <= '0;
    end else begin
      prev       <= led;
      prev_valid <= 1'b1;
      if (changed)
        dwell <= CW'(1);
      else if (dwell != '1)
        dwell <= dwell + CW'(1);
    end
  end

  // Leaving an illegal value is charged to the encoding check, never to the
  // transition check.
  always_comb begin
    enc_err   = !cur_ok || (prev_valid && !prev_ok);
    trans_err = 1'b0;
    short_yel = 1'b0;
    if (prev_valid && cur_ok && prev_ok && changed) begin
      trans_err = ((prev == LAMP_GRN) && (led == LAMP_RED)) ||
                  ((prev == LAMP_RED) && (led == LAMP_YEL)) ||
                  ((prev == LAMP_YEL) && (led == LAMP_GRN));
      short_yel = (prev == LAMP_YEL) && (led == LAMP_RED) && (dwell < YEL_MIN_C);
    end
  end

endmodule

// File: rtl/tf_conflict_monitor.sv
// Passive safety monitor for the T-intersection light controller; latches the
// first fault as a sticky report that doubles as the all-red request.
module tf_conflict_monitor
  import tf_pkg::*;
#(
  parameter int unsigned CW       = 27,
  parameter int unsigned YEL_MIN  = 2_000_000,
  parameter int unsigned MAX_HOLD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  led_M1,
  input  logic [2:0]  led_MT,
  input  logic [2:0]  led_M2,
  input  logic [2:0]  led_S,
  input  logic        clr,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  fault_lamp,
  output logic [15:0] chg_cnt
);

  localparam logic [CW-1:0] MAX_HOLD_C = CW'(MAX_HOLD);

  logic [2:0]  leds [4];
  logic [3:0]  enc_err;
  logic [3:0]  trans_err;
  logic [3:0]  short_yel;
  logic [3:0]  active;

  assign leds[0] = led_M1;
  assign leds[1] = led_MT;
  assign leds[2] = led_M2;
  assign leds[3] = led_S;

  for (genvar g = 0; g < 4; g++) begin : g_lamp
    tf_lamp_checker #(
      .CW      (CW),
      .YEL_MIN (YEL_MIN)
    ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .led       (leds[g]),
      .enc_err   (enc_err[g]),
      .trans_err (trans_err[g]),
      .short_yel (short_yel[g]),
      .active    (active[g])
    );
  end

  logic [11:0]   pat;
  logic [11:0]   prev_pat;
  logic          pat_valid;
  logic [CW-1:0] gdwell;
  logic          pat_chg;
  logic          stuck;
  logic          cf_m2mt;
  logic          cf_s;

  assign pat     = {led_M1, led_MT, led_M2, led_S};
  assign pat_chg = (pat != prev_pat);
  // Dwell keeps counting past MAX_HOLD, so equality is true for one cycle only.
  assign stuck   = (gdwell == MAX_HOLD_C);
  assign cf_m2mt = active[2] && active[1];
  assign cf_s    = active[3] && (active[0] || active[1] || active[2]);

  fault_code_e viol_code;
  lamp_idx_e   viol_lamp;
  logic        viol;

  always_comb begin
    viol      = 1'b1;
    viol_code = FC_NONE;
    viol_lamp = L_M1;
    if (|enc_err) begin
      viol_code = FC_ENC;
      viol_lamp = first_lamp(enc_err);
    end else if (cf_m2mt || cf_s) begin
      viol_code = FC_CONFLICT;
      viol_lamp = cf_m2mt ? L_M2 : L_S;
    end else if (|trans_err) begin
      viol_code = FC_TRANS;
      viol_lamp = first_lamp(trans_err);
    end else if (|short_yel) begin
      viol_code = FC_SHORT_YEL;
      viol_lamp = first_lamp(short_yel);
    end else if (stuck) begin
      viol_code = FC_STUCK;
    end else begin
      viol = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pat  <= '0;
      pat_valid <= 1'b0;
      gdwell    <= '0;
      chg_cnt   <= '0;
    end else begin
      prev_pat  <= pat;
      pat_valid <= 1'b1;
      if (pat_chg)
        gdwell <= CW'(1);
      else if (gdwell != '1)
        gdwell <= gdwell + CW'(1);
      if (pat_valid && pat_chg && (chg_cnt != '1))
        chg_cnt <= chg_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_code <= '0;
      fault_lamp <= '0;
    end else if (viol && (!fault || clr)) begin
      fault      <= 1'b1;
      fault_code <= viol_code;
      fault_lamp <= viol_lamp;
    end else if (clr) begin
      fault      <= 1'b0;
      fault_code <= '0;
      fault_lamp <= '0;
    end
  end

endmodule

// File: tb/tb_tf_conflict_monitor.sv
// Self-checking bench: directed scenarios plus randomized lamp sequences
// compared against a behavioural model of the monitor rules.
module tb_tf_conflict_monitor;

  localparam int unsigned CW       = 8;
  localparam int unsigned YEL_MIN  = 4;
  localparam int unsigned MAX_HOLD = 32;
  localparam int R = 4, Y = 2, G = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  led_M1 = '0, led_MT = '0, led_M2 = '0, led_S = '0;
  logic        clr = 1'b0;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  fault_lamp;
  logic [15:0] chg_cnt;

  tf_conflict_monitor #(
    .CW       (CW),
    .YEL_MIN  (YEL_MIN),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_M1     (led_M1),
    .led_MT     (led_MT),
    .led_M2     (led_M2),
    .led_S      (led_S),
    .clr        (clr),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_lamp (fault_lamp),
    .chg_cnt    (chg_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, rules evaluated in priority order.
  int m_prev [4];
  int m_dwell [4];
  bit m_pv;
  int m_gdwell, m_ppat, m_fault, m_code, m_lamp, m_chg;
  localparam int SAT = (1 << CW) - 1;

  function automatic bit legal(input int v);
    return v == R || v == Y || v == G;
  endfunction

  function automatic bit act(input int v);
    return v == G || v == Y;
  endfunction

  function automatic bit rule_hit(input int code, input int i, input int cur[4]);
    case (code)
      1: return !legal(cur[i]) || (m_pv && !legal(m_prev[i]));
      2: if (i == 2) return act(cur[2]) && act(cur[1]);
         else if (i == 3) return act(cur[3]) && (act(cur[0]) || act(cur[1]) || act(cur[2]));
         else return 1'b0;
      3: return m_pv && legal(cur[i]) && legal(m_prev[i]) &&
                ((m_prev[i] == G && cur[i] == R) || (m_prev[i] == R && cur[i] == Y) ||
                 (m_prev[i] == Y && cur[i] == G));
      4: return m_pv && m_prev[i] == Y && cur[i] == R && m_dwell[i] < YEL_MIN;
      5: return i == 0 && m_gdwell == MAX_HOLD;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_prev[i]  = 0;
      m_dwell[i] = 0;
    end
    m_pv = 0; m_gdwell = 0; m_ppat = 0;
    m_fault = 0; m_code = 0; m_lamp = 0; m_chg = 0;
  endtask

  task automatic model_edge(input int cur[4], input bit c);
    int vc, vl, pat;
    vc = 0; vl = 0;
    for (int code = 1; code <= 5 && vc == 0; code++)
      for (int i = 0; i < 4 && vc == 0; i++)
        if (rule_hit(code, i, cur)) begin
          vc = code;
          vl = i;
        end
    if (vc != 0 && (m_fault == 0 || c)) begin
      m_fault = 1; m_code = vc; m_lamp = vl;
    end else if (c) begin
      m_fault = 0; m_code = 0; m_lamp = 0;
    end
    pat = cur[0] * 512 + cur[1] * 64 + cur[2] * 8 + cur[3];
    if (m_pv && pat != m_ppat && m_chg < 65535) m_chg++;
    m_gdwell = (pat != m_ppat) ? 1 : (m_gdwell < SAT ? m_gdwell + 1 : SAT);
    m_ppat = pat;
    for (int i = 0; i < 4; i++) begin
      m_dwell[i] = (cur[i] != m_prev[i]) ? 1 : (m_dwell[i] < SAT ? m_dwell[i] + 1 : SAT);
      m_prev[i]  = cur[i];
    end
    m_pv = 1;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input int m1, input int mt, input int m2, input int s, input bit c);
    int cur[4];
    cur[0] = m1; cur[1] = mt; cur[2] = m2; cur[3] = s;
    led_M1 = 3'(m1); led_MT = 3'(mt); led_M2 = 3'(m2); led_S = 3'(s);
    clr = c;
    @(posedge clk);
    model_edge(cur, c);
    #1;
    check_eq("fault", 32'(fault), 32'(m_fault));
    check_eq("fault_code", 32'(fault_code), 32'(m_code));
    check_eq("fault_lamp", 32'(fault_lamp), 32'(m_lamp));
    check_eq("chg_cnt", 32'(chg_cnt), 32'(m_chg));
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic hold(input int m1, input int mt, input int m2, input int s, input int n);
    for (int k = 0; k < n; k++) step(m1, mt, m2, s, 1'b0);
  endtask

  // Asynchronous reset pulse, taken between clock edges.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_code", 32'(fault_code), 32'd0);
    check_eq("rst_chg", 32'(chg_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int rand_lamp(input int v);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 4) return int'($urandom_range(0, 7));
    if (r < 12) begin
      r = int'($urandom_range(0, 2));
      return r == 0 ? R : (r == 1 ? Y : G);
    end
    if (r < 78) return v;
    case (v)
      G: return Y;
      Y: return R;
      R: return G;
      default: return R;
    endcase
  endfunction

  initial begin
    int cur[4];
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Legal full cycle: five pattern changes, no fault.
    hold(G, R, G, R, 3);
    hold(G, R, Y, R, 4);
    hold(G, G, R, R, 3);
    hold(Y, Y, R, R, 4);
    hold(R, R, R, R, 2);
    hold(R, R, R, G, 2);
    check_eq("legal_fault", 32'(fault), 32'd0);
    check_eq("legal_chg", 32'(chg_cnt), 32'd5);

    // S/M1 conflict.
    async_reset();
    step(G, R, R, G, 1'b0);
    check_eq("cf_code", 32'(fault_code), 32'd2);
    check_eq("cf_lamp", 32'(fault_lamp), 32'd3);

    // Illegal encoding beats a simultaneous conflict.
    async_reset();
    step(G, R, 3, G, 1'b0);
    check_eq("enc_code", 32'(fault_code), 32'd1);
    check_eq("enc_lamp", 32'(fault_lamp), 32'd2);

    // Short yellow, then clear.
    async_reset();
    hold(G, R, R, R, 2);
    hold(Y, R, R, R, 2);
    step(R, R, R, R, 1'b0);
    check_eq("sy_code", 32'(fault_code), 32'd4);
    check_eq("sy_lamp", 32'(fault_lamp), 32'd0);
    step(R, R, R, R, 1'b1);
    check_eq("clr_fault", 32'(fault), 32'd0);
    check_eq("clr_code", 32'(fault_code), 32'd0);

    // Illegal red->yellow transition after one idle sample.
    async_reset();
    step(R, R, R, R, 1'b0);
    step(R, Y, R, R, 1'b0);
    check_eq("tr_code", 32'(fault_code), 32'd3);
    check_eq("tr_lamp", 32'(fault_lamp), 32'd1);

    // First sample after reset is never checked as a transition.
    async_reset();
    step(R, Y, R, R, 1'b0);
    check_eq("first_fault", 32'(fault), 32'd0);

    // Stuck watchdog, then reset mid-hold restarts the dwell.
    async_reset();
    hold(R, R, R, R, 32);
    check_eq("stuck_early", 32'(fault), 32'd0);
    step(R, R, R, R, 1'b0);
    check_eq("stuck_code", 32'(fault_code), 32'd5);
    check_eq("stuck_lamp", 32'(fault_lamp), 32'd0);
    hold(R, R, R, R, 3);
    async_reset();
    hold(R, R, R, R, 32);
    check_eq("restart_early", 32'(fault), 32'd0);
    step(R, R, R, R, 1'b0);
    check_eq("restart_code", 32'(fault_code), 32'd5);

    // Randomized lamp sequences with sporadic clear and reset.
    async_reset();
    for (int i = 0; i < 4; i++) cur[i] = R;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      for (int i = 0; i < 4; i++) cur[i] = rand_lamp(cur[i]);
      step(cur[0], cur[1], cur[2], cur[3], $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
